// File: rtl/yadmc_phase_cal.sv
// DCM phase calibration: sweeps -max_steps..+max_steps, finds the longest passing window
// and parks the DCM at its centre. Step handshake waits for ps_ready to drop and rise again.
module yadmc_phase_cal #(
  parameter int max_steps     = 64,
  parameter int settle_cycles = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       fail,
  input  logic       ps_ready,
  output logic       ps_up,
  output logic       ps_down,
  output logic       test_req,
  input  logic       test_ack,
  input  logic       test_pass,
  output logic [8:0] position,
  output logic [8:0] win_lo,
  output logic [8:0] win_hi
);

  typedef enum logic [3:0] {
    IDLE, SEEK_MIN, SETTLE, TEST, SWEEP, CENTER, FINISH,
    PS_PULSE, PS_WAIT_LOW, PS_WAIT_HIGH
  } state_t;

  localparam logic signed [8:0] pos_max     = 9'(max_steps);
  localparam logic signed [8:0] pos_min     = -pos_max;
  localparam logic [15:0]       settle_last = 16'(settle_cycles - 1);

  state_t            state;
  state_t            ret_state;
  logic signed [8:0] pos;
  logic signed [8:0] cur_start;
  logic signed [8:0] best_lo;
  logic [9:0]        cur_len;
  logic [9:0]        best_len;
  logic [15:0]       settle_cnt;

  logic [9:0]        next_len;
  logic signed [8:0] run_start;
  logic [8:0]        half_len;
  logic [8:0]        len_m1;
  logic signed [8:0] target;

  assign position  = pos;
  assign next_len  = cur_len + 10'd1;
  assign run_start = (cur_len == 10'd0) ? pos : cur_start;
  assign half_len  = 9'((best_len - 10'd1) >> 1);
  assign len_m1    = 9'(best_len - 10'd1);
  // With no passing position the DCM goes back to its reset offset.
  assign target    = (best_len == 10'd0) ? 9'sd0 : best_lo + $signed(half_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ret_state  <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      ps_up      <= 1'b0;
      ps_down    <= 1'b0;
      test_req   <= 1'b0;
      pos        <= 9'sd0;
      win_lo     <= 9'd0;
      win_hi     <= 9'd0;
      cur_start  <= 9'sd0;
      best_lo    <= 9'sd0;
      cur_len    <= 10'd0;
      best_len   <= 10'd0;
      settle_cnt <= 16'd0;
    end else begin
      ps_up   <= 1'b0;
      ps_down <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          state <= IDLE;
          if (start) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            win_lo    <= 9'd0;
            win_hi    <= 9'd0;
            cur_start <= 9'sd0;
            best_lo   <= 9'sd0;
            cur_len   <= 10'd0;
            best_len  <= 10'd0;
            state     <= SEEK_MIN;
          end
        end

        SEEK_MIN: begin
          if (pos > pos_min) begin
            if (ps_ready) begin
              ps_down   <= 1'b1;
              pos       <= pos - 9'sd1;
              ret_state <= SEEK_MIN;
              state     <= PS_PULSE;
            end
          end else begin
            settle_cnt <= 16'd0;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt == settle_last) begin
            test_req <= 1'b1;
            state    <= TEST;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end

        TEST: begin
          if (test_ack) begin
            test_req <= 1'b0;
            if (test_pass) begin
              cur_len   <= next_len;
              cur_start <= run_start;
              // Strict compare keeps the lower window on a tie.
              if (next_len > best_len) begin
                best_len <= next_len;
                best_lo  <= run_start;
              end
            end else begin
              cur_len <= 10'd0;
            end
            state <= SWEEP;
          end
        end

        SWEEP: begin
          if (pos < pos_max) begin
            if (ps_ready) begin
              ps_up      <= 1'b1;
              pos        <= pos + 9'sd1;
              settle_cnt <= 16'd0;
              ret_state  <= SETTLE;
              state      <= PS_PULSE;
            end
          end else begin
            state <= CENTER;
          end
        end

        CENTER: begin
          if (pos > target) begin
            if (ps_ready) begin
              ps_down   <= 1'b1;
              pos       <= pos - 9'sd1;
              ret_state <= CENTER;
              state     <= PS_PULSE;
            end
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            fail  <= (best_len == 10'd0);
            if (best_len != 10'd0) begin
              win_lo <= best_lo;
              win_hi <= best_lo + $signed(len_m1);
            end
            state <= FINISH;
          end
        end

        PS_PULSE:     state <= PS_WAIT_LOW;
        PS_WAIT_LOW:  if (!ps_ready) state <= PS_WAIT_HIGH;
        PS_WAIT_HIGH: if (ps_ready) state <= ret_state;
        default:      state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yadmc_phase_cal.sv
// Scoreboard bench for yadmc_phase_cal with clock-generator and pattern-tester models.
module tb_yadmc_phase_cal;
  localparam int MS = 8;
  localparam int ST = 2;
  localparam int MAXC = 5000;

  logic       clk = 1'b0;
  logic       reset, start, ps_ready, test_ack, test_pass;
  logic       busy, done, fail, ps_up, ps_down, test_req;
  logic [8:0] position, win_lo, win_hi;

  yadmc_phase_cal #(.max_steps(MS), .settle_cycles(ST)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .fail(fail),
    .ps_ready(ps_ready), .ps_up(ps_up), .ps_down(ps_down), .test_req(test_req),
    .test_ack(test_ack), .test_pass(test_pass), .position(position),
    .win_lo(win_lo), .win_hi(win_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int win_lo; int win_hi; int fail; int pos; int ups; int downs; int tests;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  int          pos_q[$];
  logic [16:0] tbl = '0;
  int          model_pos = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [16:0] mask(input int lo, input int hi);
    logic [16:0] m;
    m = '0;
    for (int p = lo; p <= hi; p++) m[p + MS] = 1'b1;
    return m;
  endfunction

  // Brute-force search over every window; earliest wins a tie.
  function automatic exp_t model(input logic [16:0] t, input int from_pos);
    exp_t e;
    int best_lo, best_len, target;
    best_lo = 0; best_len = 0;
    for (int lo = -MS; lo <= MS; lo++)
      for (int hi = lo; hi <= MS; hi++) begin
        bit all;
        all = 1'b1;
        for (int p = lo; p <= hi; p++) if (!t[p + MS]) all = 1'b0;
        if (all && (hi - lo + 1) > best_len) begin
          best_len = hi - lo + 1;
          best_lo  = lo;
        end
      end
    target   = (best_len > 0) ? best_lo + (best_len - 1) / 2 : 0;
    e.fail   = (best_len == 0) ? 1 : 0;
    e.win_lo = (best_len > 0) ? best_lo : 0;
    e.win_hi = (best_len > 0) ? best_lo + best_len - 1 : 0;
    e.pos    = target;
    e.ups    = 2 * MS;
    e.downs  = (from_pos + MS) + (MS - target);
    e.tests  = 2 * MS + 1;
    return e;
  endfunction

  // Clock generator: ready drops after each step pulse, plus occasional idle drops.
  initial begin
    int cnt;
    cnt = 0;
    ps_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        ps_ready = 1'b1; cnt = 0;
      end else if (ps_up || ps_down) begin
        ps_ready = 1'b0; cnt = $urandom_range(2, 4);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) ps_ready = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        ps_ready = 1'b0; cnt = 1;
      end
    end
  end

  // Pattern tester: random latency, answers from tbl; stray acks when idle.
  initial begin
    int td, p;
    td = -1; p = 0;
    test_ack = 1'b0; test_pass = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        test_ack = 1'b0; td = -1;
      end else if (test_ack) begin
        test_ack = 1'b0;
      end else if (test_req) begin
        if (td < 0) begin
          td = $urandom_range(0, 3);
          p = $signed(position);
          if (pos_q.size() == 0) chk("test_unexpected", 1, 0);
          else chk("test_position", p, pos_q.pop_front());
        end
        if (td == 0) begin
          test_ack  = 1'b1;
          test_pass = (p >= -MS && p <= MS) ? tbl[p + MS] : 1'b0;
          td = -1;
        end else begin
          td--;
        end
      end else begin
        test_ack  = ($urandom_range(0, 7) == 0);
        test_pass = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: counts steps/tests per run and scores each done against the queue.
  initial begin
    int ups, downs, tests, viol;
    logic pb, pd, pu, pdn, ptr, prdy, rise;
    exp_t e;
    ups = 0; downs = 0; tests = 0; viol = 0;
    pb = 0; pd = 0; pu = 0; pdn = 0; ptr = 0; prdy = 1; rise = 1;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        ups = 0; downs = 0; tests = 0; viol = 0;
        pb = 0; pd = 0; pu = 0; pdn = 0; ptr = 0; prdy = 1; rise = 1;
      end else begin
        if (busy && !pb) begin
          ups = 0; downs = 0; tests = 0; viol = 0; rise = 1;
        end
        if (ps_ready && !prdy) rise = 1;
        if (ps_up) ups++;
        if (ps_down) downs++;
        if (ps_up && ps_down) viol++;
        if ((ps_up && pu) || (ps_down && pdn)) viol++;
        if (ps_up || ps_down) begin
          if (!rise || !ps_ready) viol++;
          rise = 0;
        end
        if (test_req && !ptr) tests++;
        if (done && !pd) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("fail_flag", int'(fail), e.fail);
            chk("win_lo", int'($signed(win_lo)), e.win_lo);
            chk("win_hi", int'($signed(win_hi)), e.win_hi);
            chk("final_position", int'($signed(position)), e.pos);
            chk("up_steps", ups, e.ups);
            chk("down_steps", downs, e.downs);
            chk("test_count", tests, e.tests);
            chk("busy_falls_with_done", int'({pb, busy}), 2);
            chk("pulse_rules", viol, 0);
          end
        end
        pb = busy; pd = done; pu = ps_up; pdn = ps_down; ptr = test_req; prdy = ps_ready;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_fail"}, int'(fail), 0);
    chk({tag, "_ps_up"}, int'(ps_up), 0);
    chk({tag, "_ps_down"}, int'(ps_down), 0);
    chk({tag, "_test_req"}, int'(test_req), 0);
    chk({tag, "_position"}, int'(position), 0);
    chk({tag, "_win_lo"}, int'(win_lo), 0);
    chk({tag, "_win_hi"}, int'(win_hi), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_cal(input logic [16:0] t, input bit extra);
    exp_t e;
    int k, n;
    tbl = t;
    e = model(t, model_pos);
    exp_q.push_back(e);
    for (int p = -MS; p <= MS; p++) pos_q.push_back(p);
    model_pos = e.pos;
    pulse_start();
    if (extra) begin
      n = 0; k = 0;
      while (!(n >= 3 && test_req && test_ack) && k < MAXC) begin
        @(negedge clk);
        if (ps_up) n++;
        k++;
      end
      chk("reach_sweep", int'(n >= 3 && test_req && test_ack), 1);
      pulse_start();
    end
    k = 0;
    while (!done && k < MAXC) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
      exp_q.delete(); pos_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r, s;
    int k, n;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_cal(mask(-2, 3), 1'b0);
    run_cal(mask(-6, -5) | mask(1, 4), 1'b0);
    run_cal(mask(-6, -5) | mask(3, 4), 1'b0);
    run_cal(17'd0, 1'b0);
    run_cal(mask(7, 8), 1'b0);
    run_cal(mask(-8, -8) | mask(-1, 2), 1'b1);
    run_cal(17'h1ffff, 1'b0);
    for (int i = 0; i < 6; i++) begin
      r = $urandom; s = $urandom;
      run_cal((i % 2 == 1) ? (r[16:0] | s[16:0]) : (r[16:0] & s[16:0]), 1'b0);
    end

    // Reset while the DUT waits for ps_ready to drop after a step.
    tbl = mask(0, 3);
    for (int p = -MS; p <= MS; p++) pos_q.push_back(p);
    pulse_start();
    k = 0;
    while (!ps_down && k < MAXC) begin
      @(negedge clk);
      k++;
    end
    chk("saw_step_before_reset", int'(ps_down), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    pos_q.delete();
    model_pos = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (ps_up || ps_down) n++;
    end
    chk("no_step_after_reset", n, 0);
    chk("busy_after_reset", int'(busy), 0);

    run_cal(mask(-3, 5), 1'b0);

    chk("exp_queue_empty", exp_q.size(), 0);
    chk("pos_queue_empty", pos_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
